// File: rtl/os_psum_drain.sv
// Drains an output-stationary array one row at a time, formats each psum lane
// (shift, optional ReLU, saturate) and hands the row out over a valid/ready port.
module os_psum_drain #(
   parameter int col     = 8,
   parameter int row     = 8,
   parameter int psum_bw = 16,
   parameter int out_bw  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     relu_en,
   input  logic [2:0]               shift,
   output logic                     rd_en,
   output logic [$clog2(row)-1:0]   row_sel,
   input  logic [psum_bw*col-1:0]   psum_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [out_bw*col-1:0]    out_data,
   output logic                     acc_clr,
   output logic                     busy,
   output logic                     done
);

   localparam int rw = $clog2(row);
   localparam logic [rw-1:0] last_row = rw'(row - 1);

   // Saturation bounds expressed at the widened (psum_bw+1) working width.
   localparam logic signed [psum_bw:0] sat_max =
      {{(psum_bw - out_bw + 2){1'b0}}, {(out_bw - 1){1'b1}}};
   localparam logic signed [psum_bw:0] sat_min =
      {{(psum_bw - out_bw + 2){1'b1}}, {(out_bw - 1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, FINISH} state_t;

   state_t                  state;
   logic [2:0]              shift_reg;
   logic                    relu_reg;
   logic [out_bw*col-1:0]   fmt_row;

   genvar gi;
   generate
      for (gi = 0; gi < col; gi++) begin : g_lane
         logic signed [psum_bw:0] ext;
         logic signed [psum_bw:0] shifted;
         logic [out_bw-1:0]       lane;

         assign ext     = $signed({psum_in[psum_bw*(gi+1)-1], psum_in[psum_bw*gi +: psum_bw]});
         assign shifted = ext >>> shift_reg;
         assign lane    = (relu_reg && shifted[psum_bw]) ? '0 :
                          (shifted > sat_max)            ? sat_max[out_bw-1:0] :
                          (shifted < sat_min)            ? sat_min[out_bw-1:0] :
                                                           shifted[out_bw-1:0];
         assign fmt_row[out_bw*gi +: out_bw] = lane;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         rd_en     <= 1'b0;
         row_sel   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         acc_clr   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_reg <= 3'd0;
         relu_reg  <= 1'b0;
      end else begin
         rd_en   <= 1'b0;
         acc_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= ISSUE;
                  rd_en     <= 1'b1;
                  row_sel   <= '0;
                  busy      <= 1'b1;
                  shift_reg <= shift;
                  relu_reg  <= relu_en;
               end
            end
            ISSUE: state <= CAPTURE;
            CAPTURE: begin
               // psum_in is valid here, one cycle after the rd_en strobe.
               out_data  <= fmt_row;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (row_sel == last_row) begin
                     state   <= FINISH;
                     acc_clr <= 1'b1;
                     done    <= 1'b1;
                  end else begin
                     row_sel <= row_sel + rw'(1);
                     rd_en   <= 1'b1;
                     state   <= ISSUE;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_os_psum_drain.sv
// Randomized self-checking bench for os_psum_drain: an array responder feeds
// psums one cycle after rd_en, and expected rows come from an arithmetic model.
module tb_os_psum_drain;

   localparam int COL = 8;
   localparam int ROW = 8;
   localparam int PBW = 16;
   localparam int OBW = 8;
   localparam int RW  = $clog2(ROW);

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic                 relu_en = 1'b0;
   logic                 out_ready = 1'b0;
   logic [2:0]           shift = 3'd0;
   logic                 rd_en, out_valid, acc_clr, busy, done;
   logic [RW-1:0]        row_sel;
   logic [PBW*COL-1:0]   psum_in = '0;
   logic [OBW*COL-1:0]   out_data;

   int checks = 0;
   int errors = 0;

   int mem [ROW][COL];
   int lat_shift;
   bit lat_relu;

   logic [OBW*COL-1:0] got_data [$];
   int                 got_row  [$];
   int done_cnt, clr_cnt, done_cyc, viol, unstable;

   os_psum_drain #(.col(COL), .row(ROW), .psum_bw(PBW), .out_bw(OBW)) dut (
      .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .shift(shift),
      .rd_en(rd_en), .row_sel(row_sel), .psum_in(psum_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .acc_clr(acc_clr), .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Array model: row contents appear only in the cycle after rd_en, garbage otherwise.
   always @(posedge clk) begin : array_model
      logic r;
      int   rs;
      r  = rd_en;
      rs = int'(row_sel);
      #1;
      for (int k = 0; k < COL; k++) begin
         logic [PBW-1:0] v;
         v = r ? PBW'(mem[rs][k]) : PBW'($urandom);
         psum_in[PBW*k +: PBW] = v;
      end
   end

   // Floor division by 2^sh, optional ReLU, then clamp to the signed output range.
   function automatic int fmt(int p, int sh, bit relu);
      int d, v, hi, lo;
      d  = 1 << sh;
      hi = (1 << (OBW - 1)) - 1;
      lo = -(1 << (OBW - 1));
      if (p >= 0) v = p / d;
      else        v = -((-p + d - 1) / d);
      if (relu && v < 0) v = 0;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

   function automatic logic [OBW*COL-1:0] exp_row(int r);
      logic [OBW*COL-1:0] e;
      for (int k = 0; k < COL; k++) begin
         logic [OBW-1:0] b;
         b = OBW'(fmt(mem[r][k], lat_shift, lat_relu));
         e[OBW*k +: OBW] = b;
      end
      return e;
   endfunction

   // Runs one drain from IDLE and records what the DUT did; no comparisons here.
   task automatic run_drain(input int sh, input bit relu, input int stall_row,
                            input int stall_len, input int busy_start_cyc,
                            input bit rand_ready);
      int ncyc, stall_cnt, post;
      logic [OBW*COL-1:0] held;
      got_data.delete();
      got_row.delete();
      done_cnt = 0; clr_cnt = 0; done_cyc = -1; viol = 0; unstable = 0;
      stall_cnt = 0; post = 0; held = '0;
      lat_shift = sh;
      lat_relu  = relu;
      shift     = 3'(sh);
      relu_en   = relu;
      start     = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      shift   = 3'($urandom);
      relu_en = 1'($urandom);
      ncyc = 1;
      while (ncyc <= 400 && (done_cnt == 0 || post < 3)) begin
         if (rd_en) begin
            got_row.push_back(int'(row_sel));
            if (out_valid) viol++;
         end
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = ncyc;
         end
         if (acc_clr) clr_cnt++;
         out_ready = 1'b1;
         if (rand_ready) out_ready = 1'($urandom);
         else if (out_valid && got_data.size() == stall_row && stall_cnt < stall_len) begin
            if (stall_cnt == 0) held = out_data;
            else if (out_data !== held) unstable++;
            out_ready = 1'b0;
            stall_cnt++;
         end
         if (out_valid && out_ready) got_data.push_back(out_data);
         start = (ncyc == busy_start_cyc);
         if (done_cnt > 0) post++;
         @(posedge clk); #1;
         ncyc++;
      end
      start     = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rd_en, out_valid, acc_clr, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 00000", {rd_en, out_valid, acc_clr, busy, done});
      end
      checks++;
      if (row_sel !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_data got row_sel=%0d out_data=%0h expected 0 and 0", row_sel, out_data);
      end
      start = 1'b0;
      out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      $display("reset: checked idle outputs");
   endtask

   task automatic test_basic();
      for (int r = 0; r < ROW; r++) for (int k = 0; k < COL; k++) mem[r][k] = r;
      run_drain(0, 1'b0, -1, 0, 0, 1'b0);
      checks++;
      if (got_data.size() != ROW) begin
         errors++;
         $display("FAIL basic_rows got %0d expected %0d", got_data.size(), ROW);
      end
      for (int r = 0; r < got_data.size() && r < ROW; r++) begin
         checks++;
         if (got_data[r] !== exp_row(r) || got_row[r] !== r) begin
            errors++;
            $display("FAIL basic_row%0d got row %0d data %0h expected row %0d data %0h",
                     r, got_row[r], got_data[r], r, exp_row(r));
         end
      end
      checks++;
      if (done_cyc !== 3*ROW + 1) begin
         errors++;
         $display("FAIL basic_done_cycle got %0d expected %0d", done_cyc, 3*ROW + 1);
      end
      checks++;
      if (done_cnt !== 1 || clr_cnt !== 1 || viol !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulses got done=%0d clr=%0d viol=%0d busy=%b expected 1 1 0 0",
                  done_cnt, clr_cnt, viol, busy);
      end
      $display("basic: %0d rows, done at cycle %0d", got_data.size(), done_cyc);
   endtask

   task automatic test_format(input string name, input int pa, input int pb, input int sh, input bit relu);
      for (int r = 0; r < ROW; r++) for (int k = 0; k < COL; k++) mem[r][k] = (k % 2) ? pb : pa;
      run_drain(sh, relu, -1, 0, 0, 1'b0);
      checks++;
      if (got_data.size() != ROW || got_data[0] !== exp_row(0) || got_data[ROW-1] !== exp_row(ROW-1)) begin
         errors++;
         $display("FAIL %s got %0d rows first %0h expected %0d rows %0h", name,
                  got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, ROW, exp_row(0));
      end
      $display("%s: lane0 %0d lane1 %0d -> %0d %0d", name, pa, pb,
               fmt(pa, sh, relu), fmt(pb, sh, relu));
   endtask

   task automatic test_saturation();
      test_format("sat_norelu", 300, -300, 0, 1'b0);
      test_format("sat_relu", 300, -300, 0, 1'b1);
      test_format("shift3", 1000, -20, 3, 1'b0);
      checks++;
      if (fmt(-20, 3, 1'b0) != -3 || fmt(300, 0, 1'b1) != 127 || fmt(-300, 0, 1'b0) != -128) begin
         errors++;
         $display("FAIL model_anchor got %0d %0d %0d expected -3 127 -128",
                  fmt(-20, 3, 1'b0), fmt(300, 0, 1'b1), fmt(-300, 0, 1'b0));
      end
   endtask

   task automatic test_backpressure();
      for (int r = 0; r < ROW; r++) for (int k = 0; k < COL; k++) mem[r][k] = int'($urandom_range(0, 65535)) - 32768;
      run_drain(2, 1'b0, 2, 5, 0, 1'b0);
      checks++;
      if (unstable !== 0 || viol !== 0) begin
         errors++;
         $display("FAIL bp_stable got unstable=%0d rd_while_valid=%0d expected 0 0", unstable, viol);
      end
      for (int r = 0; r < got_data.size() && r < ROW; r++) begin
         checks++;
         if (got_data[r] !== exp_row(r) || got_row[r] !== r) begin
            errors++;
            $display("FAIL bp_row%0d got row %0d data %0h expected row %0d data %0h",
                     r, got_row[r], got_data[r], r, exp_row(r));
         end
      end
      checks++;
      if (got_data.size() != ROW || done_cyc !== 3*ROW + 1 + 5) begin
         errors++;
         $display("FAIL bp_done got rows=%0d cycle=%0d expected %0d %0d",
                  got_data.size(), done_cyc, ROW, 3*ROW + 6);
      end
      $display("backpressure: 5-cycle stall on row 2, done at cycle %0d", done_cyc);
   endtask

   task automatic test_reset_mid();
      int n, extra;
      bit found;
      found = 1'b0;
      extra = 0;
      for (int r = 0; r < ROW; r++) for (int k = 0; k < COL; k++) mem[r][k] = int'($urandom_range(0, 4000)) - 2000;
      shift = 3'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!found && n < 100) begin
         if (out_valid && row_sel == RW'(4)) found = 1'b1;
         else begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            n++;
         end
      end
      out_ready = 1'b0;
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rmid_reach got no HOLD of row 4 within 100 cycles expected reached");
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({rd_en, out_valid, acc_clr, busy, done} !== 5'b0 || row_sel !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got ctrl=%b row_sel=%0d data=%0h expected 0 0 0",
                  {rd_en, out_valid, acc_clr, busy, done}, row_sel, out_data);
      end
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (done || acc_clr || rd_en) extra++;
      end
      out_ready = 1'b0;
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL rmid_quiet got %0d active cycles expected 0", extra);
      end
      run_drain(0, 1'b1, -1, 0, 0, 1'b0);
      checks++;
      if (got_data.size() != ROW || got_row[0] !== 0 || got_data[0] !== exp_row(0) || done_cnt !== 1) begin
         errors++;
         $display("FAIL rmid_restart got rows=%0d first=%0d done=%0d expected %0d 0 1",
                  got_data.size(), (got_row.size() > 0) ? got_row[0] : -1, done_cnt, ROW);
      end
      $display("reset_mid: aborted at row 4, restart drained %0d rows", got_data.size());
   endtask

   task automatic test_start_busy();
      for (int r = 0; r < ROW; r++) for (int k = 0; k < COL; k++) mem[r][k] = r * 10 - k;
      run_drain(1, 1'b0, -1, 0, 4, 1'b0);
      checks++;
      if (got_data.size() != ROW || got_row.size() != ROW || done_cnt !== 1 || clr_cnt !== 1) begin
         errors++;
         $display("FAIL busy_start got rows=%0d reads=%0d done=%0d clr=%0d expected %0d %0d 1 1",
                  got_data.size(), got_row.size(), done_cnt, clr_cnt, ROW, ROW);
      end
      $display("start_busy: %0d rows, %0d done pulses", got_data.size(), done_cnt);
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         int sh;
         bit relu;
         sh   = int'($urandom_range(0, 7));
         relu = 1'($urandom);
         for (int r = 0; r < ROW; r++) for (int k = 0; k < COL; k++) mem[r][k] = int'($urandom_range(0, 65535)) - 32768;
         run_drain(sh, relu, -1, 0, 0, 1'b1);
         for (int r = 0; r < got_data.size() && r < ROW; r++) begin
            checks++;
            if (got_data[r] !== exp_row(r) || got_row[r] !== r) begin
               errors++;
               $display("FAIL rand%0d_row%0d got row %0d data %0h expected row %0d data %0h",
                        t, r, got_row[r], got_data[r], r, exp_row(r));
            end
         end
         checks++;
         if (got_data.size() != ROW || done_cnt !== 1 || clr_cnt !== 1 || viol !== 0) begin
            errors++;
            $display("FAIL rand%0d_ctrl got rows=%0d done=%0d clr=%0d viol=%0d expected %0d 1 1 0",
                     t, got_data.size(), done_cnt, clr_cnt, viol, ROW);
         end
         $display("random %0d: shift=%0d relu=%0d rows=%0d", t, sh, relu, got_data.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
